// File: rtl/ps2_tx_host.sv
// ps2_tx_host
//   PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set
//   LEDs, 0xF4 enable, 0xFF reset) to the attached keyboard. The shared
//   open-drain lines are driven through active-high pull-low enables, so this
//   block can sit alongside the existing PS/2 receiver on the same pads.
//   Frame: start, 8 data bits LSB first, odd parity, stop, then device ACK.
//
// Optional build macro: PS2_TX_TIMEOUT_EN
//   When defined, a watchdog aborts a transaction if the device stops
//   clocking for TIMEOUT_CYCLES clk cycles. Without it, tx_timeout is
//   tied 0 and a silent device leaves the block busy.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   ps2clk      in   raw PS/2 clock pad input
//   ps2data     in   raw PS/2 data pad input
//   tx_start    in   single-cycle request, tx_data sampled when not busy
//   tx_data     in   command byte
//   ps2clk_oe   out  1 = pull ps2clk low
//   ps2data_oe  out  1 = pull ps2data low
//   busy        out  transmission in progress
//   tx_done     out  one-cycle pulse at end of transaction
//   tx_ack_err  out  valid with tx_done, 1 = device did not ACK
//   tx_timeout  out  valid with tx_done, 1 = aborted by watchdog

module ps2_tx_host #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] RTS       = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] PARITY    = 3'd4;
  localparam logic [2:0] STOP      = 3'd5;
  localparam logic [2:0] ACK       = 3'd6;
  localparam logic [2:0] WAIT_IDLE = 3'd7;

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  logic [2:0]       state;
  logic [2:0]       clk_sync;
  logic [2:0]       data_sync;
  logic [7:0]       data_reg;
  logic             parity_reg;
  logic [2:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic             ack_err_next;
  logic             clk_fall;
  logic             data_s;

  // Pad synchronizers; idle-high reset value so reset never looks like an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2clk};
      data_sync <= {data_sync[1:0], ps2data};
    end
  end

  assign clk_fall = ~clk_sync[1] & clk_sync[2];
  assign data_s   = data_sync[2];

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;
  logic            wd_expired;

  // The watchdog only runs while the device owns the clock
  assign wd_active  = (state == RTS) || (state == DATA) || (state == PARITY) ||
                      (state == STOP) || (state == ACK) || (state == WAIT_IDLE);
  assign wd_expired = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (!wd_active || clk_fall || wd_expired) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  // The timeout limit only matters for watchdog builds
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign tx_timeout     = 1'b0;
`endif

  // Frame sequencer; every output is registered. Each device falling edge
  // moves the data line to the next bit, so the device samples it on the
  // following rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      data_reg     <= '0;
      parity_reg   <= 1'b0;
      bit_cnt      <= '0;
      inh_cnt      <= '0;
      ack_err_next <= 1'b0;
      ps2clk_oe    <= 1'b0;
      ps2data_oe   <= 1'b0;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
      tx_ack_err   <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      tx_timeout   <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start && !busy) begin
            data_reg   <= tx_data;
            parity_reg <= ~^tx_data;
            bit_cnt    <= '0;
            inh_cnt    <= INH_W'(INHIBIT_CYCLES - 1);
            busy       <= 1'b1;
            ps2clk_oe  <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == '0) begin
            // Request-to-send: release clock, pull data low as start bit
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b1;
            state      <= RTS;
          end else begin
            inh_cnt <= inh_cnt - 1'b1;
          end
        end
        RTS: begin
          if (clk_fall) begin
            ps2data_oe <= ~data_reg[0];
            state      <= DATA;
          end
        end
        DATA: begin
          if (clk_fall) begin
            bit_cnt    <= bit_cnt + 3'd1;
            ps2data_oe <= ~data_reg[bit_cnt + 3'd1];
            if (bit_cnt == 3'd6) begin
              state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (clk_fall) begin
            ps2data_oe <= ~parity_reg;
            state      <= STOP;
          end
        end
        STOP: begin
          if (clk_fall) begin
            ps2data_oe <= 1'b0;
            state      <= ACK;
          end
        end
        ACK: begin
          if (clk_fall) begin
            ack_err_next <= data_s;
            state        <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (clk_sync[2] && data_s) begin
            tx_done    <= 1'b1;
            busy       <= 1'b0;
            tx_ack_err <= ack_err_next;
`ifdef PS2_TX_TIMEOUT_EN
            tx_timeout <= 1'b0;
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // Abort overrides whatever the sequencer decided this cycle
      if (wd_expired) begin
        ps2clk_oe  <= 1'b0;
        ps2data_oe <= 1'b0;
        busy       <= 1'b0;
        tx_done    <= 1'b1;
        tx_ack_err <= 1'b1;
        tx_timeout <= 1'b1;
        state      <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_tx_host.sv
// tb_ps2_tx_host
//   Scoreboard bench for ps2_tx_host. Stimulus pushes the expected result of
//   each transaction; a monitor pops and compares on every tx_done. A PS/2
//   device model clocks the bus and captures the eleven line values it sees.

module tb_ps2_tx_host;

  localparam int INH = 100;
  localparam int TO  = 500;
  localparam int H   = 20;

  typedef struct {
    logic [10:0] frame;
    logic        ack_err;
    logic        timeout;
    bit          check_frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       dev_clk;
  logic       dev_data;
  logic       ps2clk;
  logic       ps2data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ps2clk_oe;
  logic       ps2data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_ack_err;
  logic       tx_timeout;

  exp_t        exp_q[$];
  logic [10:0] cap_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_fall_cyc = 0;
  int          inh_run = 0;

  // Open-drain wired-AND of device and host
  assign ps2clk  = dev_clk & ~ps2clk_oe;
  assign ps2data = dev_data & ~ps2data_oe;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ps2_tx_host #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2clk    (ps2clk),
    .ps2data   (ps2data),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .ps2clk_oe (ps2clk_oe),
    .ps2data_oe(ps2data_oe),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_ack_err(tx_ack_err),
    .tx_timeout(tx_timeout)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  // Inhibit length: count consecutive cycles with ps2clk pulled low
  always @(negedge clk) begin
    if (reset) begin
      inh_run <= 0;
    end else if (ps2clk_oe) begin
      inh_run <= inh_run + 1;
    end else if (inh_run != 0) begin
      checkOutput("inhibit_len", inh_run, INH);
      inh_run <= 0;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset && tx_done) begin
      if (exp_q.size() == 0) begin
        failNow("unexpected_tx_done");
      end else begin
        e = exp_q.pop_front();
        checkOutput("tx_ack_err", tx_ack_err, e.ack_err);
        checkOutput("tx_timeout", tx_timeout, e.timeout);
        checkOutput("busy_at_done", busy, 0);
        checkOutput("oe_at_done", {ps2clk_oe, ps2data_oe}, 0);
        if (e.check_frame) begin
          if (cap_q.size() == 0) failNow("frame_missing");
          else checkOutput("frame", cap_q.pop_front(), e.frame);
        end
`ifdef PS2_TX_TIMEOUT_EN
        if (e.timeout)
          checkOutput("timeout_latency", ((cyc - last_fall_cyc) >= TO) &&
                                         ((cyc - last_fall_cyc) <= TO + 6), 1);
`endif
      end
    end
  end

  // Issue one request; push its expected outcome when a tx_done is due
  task automatic applyStimulus(input logic [7:0] data, input logic [10:0] frame,
                               input logic ack_err, input logic timeout,
                               input bit check_frame, input bit expect_done);
    exp_t e;
    checkOutput("busy_before_start", busy, 0);
    if (expect_done) begin
      e.frame       = frame;
      e.ack_err     = ack_err;
      e.timeout     = timeout;
      e.check_frame = check_frame;
      exp_q.push_back(e);
    end
    tx_data  = data;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
  endtask

  // Device model: wait for request-to-send, then generate n_edges clocks,
  // sampling the line in each high phase and optionally driving ACK low
  task automatic devFrame(input int n_edges, input bit ack_low);
    int          budget;
    logic [10:0] cap;
    budget = 0;
    while (!(ps2clk_oe == 1'b0 && ps2data_oe == 1'b1) && budget < INH * 5) begin
      @(negedge clk);
      budget++;
    end
    if (!(ps2clk_oe == 1'b0 && ps2data_oe == 1'b1)) begin
      failNow("rts_not_seen");
      return;
    end
    cap = '0;
    for (int k = 0; k < n_edges; k++) begin
      repeat (H / 2) @(negedge clk);
      cap[k] = ps2data;
      if (k == 10 && ack_low) dev_data = 1'b0;
      repeat (H / 2) @(negedge clk);
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    if (n_edges == 11) cap_q.push_back(cap);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_released", busy, 0);
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL global_time_limit");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    reset    = 1'b1;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_oe", {ps2clk_oe, ps2data_oe}, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", tx_done, 0);
    checkOutput("rst_flags", {tx_ack_err, tx_timeout}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Receiver traffic while idle must be ignored
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    checkOutput("idle_ignore_busy", busy, 0);
    checkOutput("idle_ignore_oe", {ps2clk_oe, ps2data_oe}, 0);

    // 0xED set-LEDs: parity 1
    applyStimulus(8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b0, 1'b0, 1'b1, 1'b1);
    devFrame(11, 1'b1);
    waitIdle(200);

    // 0xF4 enable: parity 0
    applyStimulus(8'hF4, {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b0, 1'b0, 1'b1, 1'b1);
    devFrame(11, 1'b1);
    waitIdle(200);

    // 0x55 with no ACK from the device
    applyStimulus(8'h55, {1'b1, 1'b1, 8'h55, 1'b0}, 1'b1, 1'b0, 1'b1, 1'b1);
    devFrame(11, 1'b0);
    waitIdle(200);

    // Second request while busy is ignored
    applyStimulus(8'h3C, {1'b1, 1'b1, 8'h3C, 1'b0}, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    devFrame(11, 1'b1);
    waitIdle(200);

    // Reset after the fourth data bit releases the lines, no tx_done
    applyStimulus(8'hA5, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    devFrame(4, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("midreset_oe", {ps2clk_oe, ps2data_oe}, 0);
    checkOutput("midreset_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 0xFF after the reset: parity 1
    applyStimulus(8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b0, 1'b0, 1'b1, 1'b1);
    devFrame(11, 1'b1);
    waitIdle(200);

    // Device stops clocking after bit 2
`ifdef PS2_TX_TIMEOUT_EN
    applyStimulus(8'hF4, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    devFrame(3, 1'b1);
    waitIdle(TO * 2);
`else
    applyStimulus(8'hF4, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    devFrame(3, 1'b1);
    repeat (TO * 3) @(negedge clk);
    checkOutput("silent_device_busy", busy, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`endif

    repeat (20) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_tx_host.md
Name: ps2_tx_host

Overview:
- PS/2 host-to-device transmitter; sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset).
- Drives the shared open-drain ps2clk/ps2data lines through active-high pull-low enables, alongside the existing PS/2 receiver.
- Synchronizes and edge-detects the device clock itself; frame is start, 8 data bits LSB first, odd parity, stop, device ACK.

Parameters:
- INHIBIT_CYCLES, 10000, clk cycles ps2clk is held low before request-to-send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000, max clk cycles allowed between device clock falling edges (used only with PS2_TX_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- ps2clk  in  1  raw PS/2 clock line (pad input).
- ps2data  in  1  raw PS/2 data line (pad input).
- tx_start  in  1  single-cycle request; tx_data is sampled when tx_start=1 and busy=0.
- tx_data  in  8  command byte.
- ps2clk_oe  out  1  1 = pull ps2clk low, 0 = release.
- ps2data_oe  out  1  1 = pull ps2data low, 0 = release.
- busy  out  1  transmission in progress.
- tx_done  out  1  one-cycle pulse at end of transaction (success or error).
- tx_ack_err  out  1  valid with tx_done; 1 = device did not ACK.
- tx_timeout  out  1  valid with tx_done; 1 = aborted by watchdog (always 0 without macro).

Behaviour:
- Reset: ps2clk_oe=0, ps2data_oe=0, busy=0, tx_done=0, tx_ack_err=0, tx_timeout=0; sync flops=1; state IDLE.
- Sync: ps2clk/ps2data pass through 3 flops each, reset value 1. Falling edge = sync1 low and sync2 high. Data sample = sync2.
- Shift register holds tx_data; parity = ~^tx_data (odd parity).
- IDLE: tx_start with busy=0 latches data and parity, sets bit_cnt=0, loads the inhibit counter. Next state INHIBIT, busy=1 from the next cycle. tx_start while busy is ignored.
- INHIBIT: ps2clk_oe=1, ps2data_oe=0 for INHIBIT_CYCLES cycles. Then go to RTS.
- RTS: ps2data_oe=1 (start bit 0), ps2clk_oe=0. On a falling edge, drive data bit 0 (ps2data_oe = ~bit) and go to DATA.
- DATA: on each falling edge, drive the next bit (LSB first) and increment bit_cnt. After the falling edge that drives bit 7, go to PARITY.
- PARITY: on a falling edge, drive the parity bit and go to STOP.
- STOP: on a falling edge, set ps2data_oe=0 (stop bit 1, line released) and go to ACK.
- ACK: on a falling edge, sample data; tx_ack_err_next = sample (1 = no ACK). Go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clk=1 and data=1. Then pulse tx_done for 1 cycle, drop busy in the same cycle, and return to IDLE.
- Outputs tx_ack_err/tx_timeout hold their values until the next tx_done.
- Outputs are registered. Bus edge-to-oe latency is 3 clk cycles (sync) + 1 (register).
- ps2clk_oe is 1 only in INHIBIT. Both enables are 0 in IDLE and WAIT_IDLE.
- Reset mid-frame: both lines are released immediately (asynchronous) and no tx_done is issued.
- A device clock edge in IDLE/INHIBIT is ignored. The transmitter must not react to receiver traffic while IDLE.

Optional Feature:
- Macro PS2_TX_TIMEOUT_EN.
- Defined: a watchdog counter runs in states RTS through WAIT_IDLE and clears on every synced ps2clk falling edge. When it reaches TIMEOUT_CYCLES, the block releases both lines, pulses tx_done with tx_timeout=1 and tx_ack_err=1, drops busy, and returns to IDLE.
- Not defined: no counter is built, tx_timeout is tied 0, and a silent device leaves the block waiting indefinitely with busy=1.

Test Plan:
- Send 0xED; device model clocks 11 falling edges and drives ACK low. Expect:
  - ps2clk_oe high for exactly INHIBIT_CYCLES cycles.
  - Sampled bits 0,1,0,1,1,0,1,1,1 (start, data LSB first).
  - Parity 1, stop 1.
  - tx_done pulse with tx_ack_err=0, busy 0 afterwards.
- Send 0xF4 → data bits 0,0,1,0,1,1,1,1, parity 0, ACK ok, tx_ack_err=0.
- Device leaves data high during the ACK clock → tx_done with tx_ack_err=1, both oe=0.
- tx_start pulsed again while busy with 0x00 → ignored; the frame in progress still carries the original byte; exactly one tx_done.
- Assert reset after the 4th data bit → ps2clk_oe=ps2data_oe=0 and busy=0 immediately, no tx_done. A new tx_start 0xFF afterwards completes with parity 1.
- PS2_TX_TIMEOUT_EN with TIMEOUT_CYCLES=500; device stops clocking after bit 2 → tx_done at 500 cycles after the last edge, tx_timeout=1, lines released. Without the macro, busy stays 1.
